// File: rtl/nano_mem_responder.sv
// NanoCPU memory-side responder: RAM with a clear/load/run sequencer, CPU reset
// hold-off until the program image is loaded, access counters and write protection.
module nano_mem_responder #(
  parameter int                ADDR_W     = 8,
  parameter int                DATA_W     = 16,
  parameter logic [DATA_W-1:0] FILL       = {DATA_W{1'b0}},
  parameter int                PROT_LIMIT = 0,
  parameter int                CNT_W      = 16
) (
  input  logic              ck,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] dataR,
  input  logic [DATA_W-1:0] dataW,
  input  logic              ce,
  input  logic              we,
  output logic              cpu_rst,
  input  logic              ld_start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count,
  output logic              wr_fault
);

  localparam int DEPTH = 1 << ADDR_W;
  // One extra bit so a limit equal to DEPTH still protects every address.
  localparam logic [ADDR_W:0] PROT_LIM = PROT_LIMIT[ADDR_W:0];

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] ptr_reg;
  logic              cpu_rst_reg;
  logic [CNT_W-1:0]  rd_count_reg, wr_count_reg;
  logic              wr_fault_reg;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic in_run, prot_hit, cpu_wr, cpu_rd, cpu_fault;

  assign in_run    = (state_reg == ST_RUN);
  assign prot_hit  = ({1'b0, address} < PROT_LIM);
  assign cpu_wr    = in_run && ce && we && !prot_hit;
  assign cpu_fault = in_run && ce && we && prot_hit;
  assign cpu_rd    = in_run && ce && !we;

  always_comb begin
    state_next = state_reg;
    mem_we     = 1'b0;
    mem_waddr  = ptr_reg;
    mem_wdata  = FILL;
    case (state_reg)
      ST_CLEAR: begin
        mem_we = 1'b1;
        if (&ptr_reg) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        if (ld_valid) begin
          mem_we    = 1'b1;
          mem_waddr = ld_addr;
          mem_wdata = ld_data;
          if (ld_last) state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cpu_wr) begin
          mem_we    = 1'b1;
          mem_waddr = address;
          mem_wdata = dataW;
        end
        if (ld_start) state_next = ST_LOAD;
      end
      default: state_next = ST_CLEAR;
    endcase
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_CLEAR;
      ptr_reg      <= '0;
      cpu_rst_reg  <= 1'b1;
      rd_count_reg <= '0;
      wr_count_reg <= '0;
      wr_fault_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cpu_rst_reg <= (state_next != ST_RUN);
      if (state_reg == ST_CLEAR) ptr_reg <= ptr_reg + 1'b1;
      // Counters saturate so long runs never alias back to small values.
      if (cpu_rd && !(&rd_count_reg)) rd_count_reg <= rd_count_reg + 1'b1;
      if (cpu_wr && !(&wr_count_reg)) wr_count_reg <= wr_count_reg + 1'b1;
      if (cpu_fault) wr_fault_reg <= 1'b1;
    end
  end

  // RAM contents are deliberately not reset; the CLEAR sweep overwrites them.
  always_ff @(posedge ck) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign dataR    = in_run ? mem[address] : '0;
  assign ld_ready = (state_reg == ST_LOAD);
  assign state    = state_reg;
  assign cpu_rst  = cpu_rst_reg;
  assign rd_count = rd_count_reg;
  assign wr_count = wr_count_reg;
  assign wr_fault = wr_fault_reg;

endmodule

// File: doc/nano_mem_responder.md
Name: nano_mem_responder

Overview:
- Memory-side responder for the NanoCPU bus (address/dataR/dataW/ce/we): a 2**ADDR_W x DATA_W RAM that serves CPU reads and writes.
- Adds a sequencer that clears the RAM after reset and accepts a program image over a host load port.
- Holds the CPU in reset until the image is loaded.
- Provides access counters and optional low-address write protection.
- Sits between the NanoCPU and the system/bench loader.

Parameters:
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W words.
- DATA_W, 16, word width.
- FILL, 16'h0000, value written to every word during CLEAR.
- PROT_LIMIT, 0, CPU writes to address < PROT_LIMIT are rejected; 0 disables protection.
- CNT_W, 16, width of the access counters.

Ports:
- ck  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- address  in  ADDR_W  CPU word address.
- dataR  out  DATA_W  read data to CPU.
- dataW  in  DATA_W  write data from CPU.
- ce  in  1  CPU access enable.
- we  in  1  CPU write enable; qualified by ce.
- cpu_rst  out  1  active-high reset to the NanoCPU.
- ld_start  in  1  request re-entry to LOAD from RUN.
- ld_valid  in  1  host load word valid.
- ld_ready  out  1  responder accepts load words.
- ld_addr  in  ADDR_W  load word address.
- ld_data  in  DATA_W  load word data.
- ld_last  in  1  final load word; qualified by ld_valid.
- state  out  2  CLEAR=0, LOAD=1, RUN=2.
- rd_count  out  CNT_W  accepted CPU reads.
- wr_count  out  CNT_W  accepted CPU writes.
- wr_fault  out  1  sticky flag: a protected write was rejected.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=CLEAR, clear pointer=0.
  - cpu_rst=1, ld_ready=0, rd_count=0, wr_count=0, wr_fault=0.
  - RAM contents are not reset; CLEAR overwrites them.
- CLEAR:
  - Each cycle, mem[ptr]<=FILL and ptr increments.
  - The cycle that writes ptr==DEPTH-1 moves state to LOAD.
  - Duration is exactly DEPTH cycles after reset release.
  - CPU and load inputs are ignored.
- LOAD:
  - ld_ready=1, driven combinationally from state.
  - ld_valid=1 writes mem[ld_addr]<=ld_data.
  - ld_valid & ld_last writes the word, then state=RUN next cycle.
  - ld_last without ld_valid is ignored; ld_start is ignored.
  - Repeated addresses: last write wins.
- RUN:
  - ld_ready=0.
  - Write: ce & we & (address >= PROT_LIMIT) -> mem[address]<=dataW at posedge, wr_count+1.
  - Rejected write: ce & we & (address < PROT_LIMIT) -> no RAM write, wr_fault<=1, wr_count unchanged.
  - Read: ce & ~we -> rd_count+1.
  - ld_start=1 -> state=LOAD next cycle. A CPU access in that same cycle still completes and is counted.
- dataR:
  - Combinational mem[address] in RUN, independent of ce.
  - Same-cycle write is not forwarded: the new value appears after the posedge.
  - Outside RUN, dataR = 0.
- cpu_rst:
  - Registered; equals (next state != RUN).
  - Deasserts on the first RUN cycle; reasserts on the first LOAD cycle after ld_start.
- Counters:
  - Saturate at all-ones; no wrap.
  - Cleared only by rst; preserved across RUN->LOAD->RUN.
- wr_fault: cleared only by rst.
- Reset mid-operation (any state): immediate return to reset values. A partially loaded image is lost to the next CLEAR.

Test Plan:
- Release rst at t0 -> state=0 for exactly 256 cycles, then state=1 and ld_ready=1; cpu_rst=1 and dataR=0 throughout.
- Load words 0..10 = 4000,4111,0093,6110,8000,7203,3032,10A1,F000,000A,0000, with ld_last on addr 10 -> next cycle state=2, cpu_rst=0; address=9 gives dataR=000A, address=200 gives dataR=FILL.
- RUN, ce=1 we=1 address=10 dataW=002D -> after the posedge dataR@10=002D and wr_count=1; then three ce=1 we=0 cycles -> rd_count=3; ce=0 cycles change neither counter.
- PROT_LIMIT=9, RUN, write address=3 dataW=FFFF -> mem[3] unchanged, wr_fault=1 and stays 1; a following write to 10 is accepted and wr_count increments.
- In LOAD after 5 words, pull rst low mid-cycle -> state=0, ld_ready=0, cpu_rst=1 immediately; after the new CLEAR, word 2 reads FILL once RUN is reached.
- CNT_W=4, RUN, 20 reads, then ld_start=1 together with a write to 10 -> rd_count=15 (saturated), write lands, state=1 and cpu_rst=1 next cycle, counters held; reload and return to RUN -> counters unchanged.
